// File: rtl/tx_port_responder.sv
// Two-requester transmit port: a priority arbiter grants the port, granted
// writes are queued as {cntl,data} commands, and an executor drains the queue
// onto the USB line outputs, holding each driven line state for a minimum time.
module tx_port_responder #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    output logic       gnt0,
    output logic       gnt1,
    input  logic       wEn0,
    input  logic       wEn1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [7:0] cntl0,
    input  logic [7:0] cntl1,
    output logic       txPortRdy,
    output logic [1:0] txLineState,
    output logic       txOE,
    output logic       badCntl,
    output logic       overflow
);

    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = AW + 1;
    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [CW-1:0]  OCC_FULL    = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]  OCC_RDY_MAX = CW'(FIFO_DEPTH - 2);
    localparam logic [HCW-1:0] HOLD_LAST   = HCW'(HOLD_CYCLES - 1);
    localparam logic [7:0]     CMD_DRIVE   = 8'h00;
    localparam logic [7:0]     CMD_IDLE_J  = 8'h05;
    localparam logic [1:0]     LINE_J      = 2'b01;

    typedef enum logic [1:0] {ARB_IDLE, ARB_G0, ARB_G1} arbState_t;
    typedef enum logic       {EX_IDLE, EX_HOLD}         exState_t;

    arbState_t     arbState;
    exState_t      exState;
    logic [HCW-1:0] holdCnt;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [CW-1:0] occ;
    logic [CW-1:0] occNext;

    logic          pushReq;
    logic [15:0]   pushEntry;
    logic          fifoFull;
    logic          fifoEmpty;
    logic          doPush;
    logic          doPop;
    logic [7:0]    headCntl;
    logic [1:0]    headLine;

    // Only the granted requester's strobe and payload reach the queue.
    assign pushReq   = (gnt0 && wEn0) || (gnt1 && wEn1);
    assign pushEntry = gnt1 ? {cntl1, data1} : {cntl0, data0};

    // Fullness is judged on the occupancy at the start of the cycle, so a pop
    // in the same cycle does not make room for a write that arrives when full.
    assign fifoFull  = (occ == OCC_FULL);
    assign fifoEmpty = (occ == '0);
    assign doPush    = pushReq && !fifoFull;
    assign doPop     = !fifoEmpty && ((exState == EX_IDLE) || (holdCnt == HOLD_LAST));
    assign occNext   = occ + CW'(doPush) - CW'(doPop);

    assign headCntl  = mem[rdPtr][15:8];
    assign headLine  = mem[rdPtr][1:0];

    // Arbiter: requester 0 wins from idle; a grant lasts while its request
    // stays high, and every release passes through idle for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arbState <= ARB_IDLE;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
        end else begin
            case (arbState)
                ARB_IDLE: begin
                    if (req0) begin
                        arbState <= ARB_G0;
                        gnt0     <= 1'b1;
                    end else if (req1) begin
                        arbState <= ARB_G1;
                        gnt1     <= 1'b1;
                    end
                end
                ARB_G0: begin
                    if (!req0) begin
                        arbState <= ARB_IDLE;
                        gnt0     <= 1'b0;
                    end
                end
                ARB_G1: begin
                    if (!req1) begin
                        arbState <= ARB_IDLE;
                        gnt1     <= 1'b0;
                    end
                end
                default: begin
                    arbState <= ARB_IDLE;
                    gnt0     <= 1'b0;
                    gnt1     <= 1'b0;
                end
            endcase
        end
    end

    // Queue storage: payload only, no reset needed since occupancy guards reads.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushEntry;
        end
    end

    // Queue control: pointers, occupancy, look-ahead ready and overflow pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occ       <= '0;
            txPortRdy <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            occ       <= occNext;
            txPortRdy <= (occNext <= OCC_RDY_MAX);
            overflow  <= pushReq && fifoFull;
        end
    end

    // Executor: pops a command when idle or when the current hold has run its
    // full length, drives the line, and saturates the hold counter when starved.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exState     <= EX_IDLE;
            holdCnt     <= '0;
            txLineState <= LINE_J;
            txOE        <= 1'b0;
            badCntl     <= 1'b0;
        end else begin
            badCntl <= 1'b0;
            if (doPop) begin
                case (headCntl)
                    CMD_DRIVE: begin
                        txLineState <= headLine;
                        txOE        <= 1'b1;
                        holdCnt     <= '0;
                        exState     <= EX_HOLD;
                    end
                    CMD_IDLE_J: begin
                        txLineState <= LINE_J;
                        txOE        <= 1'b0;
                        holdCnt     <= '0;
                        exState     <= EX_HOLD;
                    end
                    default: begin
                        badCntl <= 1'b1;
                        exState <= EX_IDLE;
                    end
                endcase
            end else if (exState == EX_HOLD) begin
                if (holdCnt == HOLD_LAST) begin
                    exState <= EX_IDLE;
                end else begin
                    holdCnt <= holdCnt + HCW'(1);
                end
            end
        end
    end

endmodule
